// File: rtl/y86_pkg.sv
// y86_pkg: Y86-64 icode/status constants, fetch FSM states and the fetch status encoder.
package y86_pkg;
    localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, CMOVXX = 4'h2, IRMOVQ = 4'h3;
    localparam logic [3:0] RMMOVQ = 4'h4, MRMOVQ = 4'h5, OPQ = 4'h6, JXX = 4'h7;
    localparam logic [3:0] CALL = 4'h8, RET = 4'h9, PUSHQ = 4'hA, POPQ = 4'hB;
    localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
    typedef enum logic [1:0] {RUN, HOLD, DONE} state_t;
    function automatic logic [2:0] fetch_stat(input logic imem_error, input logic instr_valid, input logic hlt);
        return imem_error ? ADR : !instr_valid ? INS : hlt ? HLT : AOK;
    endfunction
endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// fetch_pc_ctrl_if: pipeline-side signals of the fetch PC controller.
interface fetch_pc_ctrl_if #(parameter int CNT_W = 32);
    logic             F_stall;
    logic [3:0]       M_icode;
    logic             M_Cnd;
    logic [63:0]      M_valA;
    logic [3:0]       W_icode;
    logic [63:0]      W_valM;
    logic [2:0]       W_stat;
    logic [3:0]       f_icode;
    logic [63:0]      f_valC;
    logic [63:0]      f_valP;
    logic             f_hlt;
    logic             f_imem_error;
    logic             f_instr_valid;
    logic [63:0]      f_pc;
    logic [63:0]      F_predPC;
    logic [2:0]       f_stat;
    logic             f_valid;
    logic             halted;
    logic [CNT_W-1:0] fetch_count;
    modport master(
        output F_stall, M_icode, M_Cnd, M_valA, W_icode, W_valM, W_stat,
               f_icode, f_valC, f_valP, f_hlt, f_imem_error, f_instr_valid,
        input  f_pc, F_predPC, f_stat, f_valid, halted, fetch_count
    );
    modport slave(
        input  F_stall, M_icode, M_Cnd, M_valA, W_icode, W_valM, W_stat,
               f_icode, f_valC, f_valP, f_hlt, f_imem_error, f_instr_valid,
        output f_pc, F_predPC, f_stat, f_valid, halted, fetch_count
    );
endinterface

// File: rtl/fetch_pc_select.sv
// fetch_pc_select: redirect-priority PC mux (mispredict > ret > prediction) and next-PC prediction.
module fetch_pc_select
    import y86_pkg::*;
(
    input  logic [3:0]  M_icode,
    input  logic        M_Cnd,
    input  logic [63:0] M_valA,
    input  logic [3:0]  W_icode,
    input  logic [63:0] W_valM,
    input  logic [63:0] F_predPC,
    input  logic [3:0]  f_icode,
    input  logic [63:0] f_valC,
    input  logic [63:0] f_valP,
    output logic [63:0] f_pc,
    output logic [63:0] next_pc,
    output logic        redirect
);
    logic mispredict, ret_done;
    always_comb begin
        mispredict = (M_icode == JXX) && !M_Cnd;
        ret_done   = (W_icode == RET);
        redirect   = mispredict || ret_done;
        f_pc       = mispredict ? M_valA : ret_done ? W_valM : F_predPC;
        next_pc    = (f_icode == JXX || f_icode == CALL) ? f_valC : f_valP;
    end
endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: F register, fetch status and RUN/HOLD/DONE fetch FSM for the Y86-64 pipeline.
module fetch_pc_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'd10,
    parameter int          CNT_W    = 32
) (
    input logic            clk,
    input logic            rst_n,
    fetch_pc_ctrl_if.slave bus
);
    state_t           state;
    logic [63:0]      pred_pc, pc, next_pc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       stat;
    logic             redirect, valid, accept;

    fetch_pc_select u_sel (
        .M_icode  (bus.M_icode),
        .M_Cnd    (bus.M_Cnd),
        .M_valA   (bus.M_valA),
        .W_icode  (bus.W_icode),
        .W_valM   (bus.W_valM),
        .F_predPC (pred_pc),
        .f_icode  (bus.f_icode),
        .f_valC   (bus.f_valC),
        .f_valP   (bus.f_valP),
        .f_pc     (pc),
        .next_pc  (next_pc),
        .redirect (redirect)
    );

    assign stat   = fetch_stat(bus.f_imem_error, bus.f_instr_valid, bus.f_hlt);
    assign valid  = (state == RUN) || (state == HOLD && redirect);
    assign accept = valid && !bus.F_stall;

    assign bus.f_pc        = pc;
    assign bus.F_predPC    = pred_pc;
    assign bus.f_stat      = stat;
    assign bus.f_valid     = valid;
    assign bus.halted      = (state == DONE);
    assign bus.fetch_count = cnt;

    // A faulting instruction parks the F register on its own PC until a redirect or retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc <= RESET_PC;
            state   <= RUN;
            cnt     <= '0;
        end else if (bus.W_stat != AOK) begin
            state <= DONE;
        end else if (accept) begin
            pred_pc <= (stat == AOK) ? next_pc : pc;
            state   <= (stat == AOK) ? RUN : HOLD;
            if (!(&cnt)) cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed vector table plus async-reset and counter-saturation sequences.
module tb_fetch_pc_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    // Narrow counter so saturation is reachable in a short run.
    fetch_pc_ctrl_if #(.CNT_W(4)) bus ();
    fetch_pc_ctrl #(.RESET_PC(64'd10), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        stall;
        logic [3:0]  m_icode;
        logic        m_cnd;
        logic [63:0] m_vala;
        logic [3:0]  w_icode;
        logic [63:0] w_valm;
        logic [2:0]  w_stat;
        logic [3:0]  icode;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        hlt;
        logic        ierr;
        logic        ivld;
        logic [63:0] e_pc;
        logic [63:0] e_pred;
        logic [2:0]  e_stat;
        logic        e_valid;
        logic        e_halted;
        logic [3:0]  e_cnt;
    } vec_t;

    vec_t v [21];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        bus.F_stall       = x.stall;
        bus.M_icode       = x.m_icode;
        bus.M_Cnd         = x.m_cnd;
        bus.M_valA        = x.m_vala;
        bus.W_icode       = x.w_icode;
        bus.W_valM        = x.w_valm;
        bus.W_stat        = x.w_stat;
        bus.f_icode       = x.icode;
        bus.f_valC        = x.valc;
        bus.f_valP        = x.valp;
        bus.f_hlt         = x.hlt;
        bus.f_imem_error  = x.ierr;
        bus.f_instr_valid = x.ivld;
    endtask

    task automatic idle(input logic [63:0] valp, input logic hlt);
        vec_t x;
        x = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        x.valp = valp;
        x.hlt  = hlt;
        drive(x);
    endtask

    initial begin
        //      stl mi mc mvA    wi wvM   ws fi fC     fP     h e v   pc     pred   st vl hl cnt
        v[0]  = '{0, 1, 0, 0,     1, 0,     1, 4, 0,     'h14,  0, 0, 1, 'hA,   'hA,   1, 1, 0, 0};
        v[1]  = '{0, 1, 0, 0,     1, 0,     1, 6, 0,     'h1F,  0, 0, 1, 'h14,  'h14,  1, 1, 0, 1};
        v[2]  = '{0, 1, 0, 0,     1, 0,     1, 8, 'h40,  'h28,  0, 0, 1, 'h1F,  'h1F,  1, 1, 0, 2};
        v[3]  = '{0, 1, 0, 0,     1, 0,     1, 6, 0,     'h66,  0, 0, 1, 'h40,  'h40,  1, 1, 0, 3};
        v[4]  = '{0, 7, 0, 'h2D,  9, 'h64,  1, 1, 0,     'h2E,  0, 0, 1, 'h2D,  'h66,  1, 1, 0, 4};
        v[5]  = '{0, 1, 0, 0,     9, 'h64,  1, 1, 0,     'h65,  0, 0, 1, 'h64,  'h2E,  1, 1, 0, 5};
        v[6]  = '{0, 7, 1, 'h99,  1, 0,     1, 7, 'h6C,  'h6E,  0, 0, 1, 'h65,  'h65,  1, 1, 0, 6};
        v[7]  = '{0, 1, 0, 0,     1, 0,     1, 0, 0,     'h6D,  1, 0, 1, 'h6C,  'h6C,  2, 1, 0, 7};
        v[8]  = '{0, 1, 0, 0,     1, 0,     1, 0, 0,     'h6D,  1, 0, 1, 'h6C,  'h6C,  2, 0, 0, 8};
        v[9]  = '{0, 7, 0, 'h50,  1, 0,     1, 3, 0,     'h5A,  0, 0, 1, 'h50,  'h6C,  1, 1, 0, 8};
        v[10] = '{0, 1, 0, 0,     1, 0,     1, 1, 0,     'h5B,  1, 1, 0, 'h5A,  'h5A,  3, 1, 0, 9};
        v[11] = '{0, 1, 0, 0,     9, 'h70,  1, 1, 0,     'h72,  0, 0, 0, 'h70,  'h5A,  4, 1, 0, 10};
        v[12] = '{1, 1, 0, 0,     9, 'h80,  1, 1, 0,     'h82,  0, 0, 1, 'h80,  'h70,  1, 1, 0, 11};
        v[13] = '{0, 1, 0, 0,     9, 'h80,  1, 1, 0,     'h82,  0, 0, 1, 'h80,  'h70,  1, 1, 0, 11};
        v[14] = '{1, 1, 0, 0,     1, 0,     1, 1, 0,     'h90,  0, 0, 1, 'h82,  'h82,  1, 1, 0, 12};
        v[15] = '{1, 1, 0, 0,     1, 0,     1, 1, 0,     'h90,  0, 0, 1, 'h82,  'h82,  1, 1, 0, 12};
        v[16] = '{1, 1, 0, 0,     1, 0,     1, 1, 0,     'h90,  0, 0, 1, 'h82,  'h82,  1, 1, 0, 12};
        v[17] = '{0, 1, 0, 0,     1, 0,     1, 1, 0,     'h90,  0, 0, 1, 'h82,  'h82,  1, 1, 0, 12};
        v[18] = '{0, 1, 0, 0,     1, 0,     2, 1, 0,     'hA0,  0, 0, 1, 'h90,  'h90,  1, 1, 0, 13};
        v[19] = '{0, 7, 0, 'h50,  1, 0,     1, 1, 0,     'hA0,  0, 0, 1, 'h50,  'h90,  1, 0, 1, 13};
        v[20] = '{0, 1, 0, 0,     9, 'h64,  1, 1, 0,     'hA0,  0, 0, 1, 'h64,  'h90,  1, 0, 1, 13};

        idle(64'h14, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (v[i]) begin
            if (i > 0) @(negedge clk);
            drive(v[i]);
            #1;
            chk($sformatf("v%0d f_pc", i), bus.f_pc, v[i].e_pc);
            chk($sformatf("v%0d F_predPC", i), bus.F_predPC, v[i].e_pred);
            chk($sformatf("v%0d f_stat", i), 64'(bus.f_stat), 64'(v[i].e_stat));
            chk($sformatf("v%0d f_valid", i), 64'(bus.f_valid), 64'(v[i].e_valid));
            chk($sformatf("v%0d halted", i), 64'(bus.halted), 64'(v[i].e_halted));
            chk($sformatf("v%0d fetch_count", i), 64'(bus.fetch_count), 64'(v[i].e_cnt));
        end

        // Reset out of DONE, then reach HOLD with five fetches and reset again mid-cycle.
        @(negedge clk);
        idle(64'h14, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("done_reset halted", 64'(bus.halted), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        idle(64'h14, 1'b1);
        @(negedge clk);
        #1;
        chk("hold f_valid", 64'(bus.f_valid), 64'd0);
        chk("hold fetch_count", 64'(bus.fetch_count), 64'd5);
        chk("hold F_predPC", bus.F_predPC, 64'h14);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async F_predPC", bus.F_predPC, 64'd10);
        chk("async fetch_count", 64'(bus.fetch_count), 64'd0);
        chk("async halted", 64'(bus.halted), 64'd0);
        chk("async f_valid", 64'(bus.f_valid), 64'd1);
        chk("async f_pc", bus.f_pc, 64'd10);

        // Counter saturates at all-ones.
        @(negedge clk);
        idle(64'h30, 1'b0);
        rst_n = 1'b1;
        repeat (17) @(negedge clk);
        #1;
        chk("sat fetch_count", 64'(bus.fetch_count), 64'hF);
        chk("sat F_predPC", bus.F_predPC, 64'h30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
